hex_segment_reader: RTL

Reads a 7-bit active-low seven-segment bus back into a 3-bit digit value. This is the inverse of the 3-bit-to-seven-segment display decoder.
- Synchronises the asynchronous segment input and requires the pattern to hold steady for a programmable number of cycles.
- Reports each newly settled glyph once, through a valid/ready output register.
- Sits between an external or board-level segment bus (HEX-style, bit 0 = segment a … bit 6 = segment g, 0 = lit) and downstream logic such as LEDR indicators or a checker.

---
 rtl/hex_segment_reader.sv | 110 +++++++++++
 1 files changed

// File: rtl/hex_segment_reader.sv
// Reads an active-low seven-segment bus back into a 3-bit digit; patterns must settle for
// STABLE_CYCLES before a one-shot report (STABLE_CYCLES+3 edges latency); reports arriving while full are dropped and flagged.
module hex_segment_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [6:0] SEG_IN,
  input  logic       OUT_READY,
  output logic       OUT_VALID,
  output logic [2:0] VALUE,
  output logic       ERR,
  output logic       OVERRUN
);

  localparam logic [6:0] BLANK  = 7'h7F;
  localparam logic [7:0] SC     = 8'(STABLE_CYCLES);
  localparam logic [7:0] SC_M1  = 8'(STABLE_CYCLES - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  logic [6:0] s1, s2, cand, last_acc;
  logic [7:0] cnt;
  state_t     state;

  logic       accept;
  logic       fresh;
  logic       hit;
  logic [2:0] digit;
  logic       rpt;
  logic       rpt_err;
  logic       hs;

  always_comb begin
    hit   = 1'b1;
    digit = 3'd0;
    case (cand)
      7'h40:   digit = 3'd0;
      7'h79:   digit = 3'd1;
      7'h24:   digit = 3'd2;
      7'h30:   digit = 3'd3;
      7'h19:   digit = 3'd4;
      7'h12:   digit = 3'd5;
      7'h02:   digit = 3'd6;
      7'h78:   digit = 3'd7;
      default: hit = 1'b0;
    endcase
  end

  // One accept per stable run; a run matching the previous accept is a glitch-and-return.
  assign accept  = (s2 == cand) && (cnt == SC_M1);
  assign fresh   = accept && (cand != last_acc);
  assign rpt     = fresh && (cand != BLANK);
  assign rpt_err = !hit;
  assign hs      = (state == FULL) && OUT_READY;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      s1       <= BLANK;
      s2       <= BLANK;
      cand     <= BLANK;
      cnt      <= 8'd0;
      last_acc <= BLANK;
    end else begin
      s1 <= SEG_IN;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= 8'd0;
      end else if (cnt < SC) begin
        cnt <= cnt + 8'd1;
      end
      if (fresh)
        last_acc <= cand;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state   <= EMPTY;
      VALUE   <= 3'd0;
      ERR     <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (rpt) begin
            VALUE <= rpt_err ? 3'd0 : digit;
            ERR   <= rpt_err;
            state <= FULL;
          end
        end
        FULL: begin
          if (rpt && hs) begin
            VALUE <= rpt_err ? 3'd0 : digit;
            ERR   <= rpt_err;
          end else if (hs) begin
            state <= EMPTY;
          end else if (rpt) begin
            OVERRUN <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign OUT_VALID = (state == FULL);

endmodule
